// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Arbitrates the single external 16-bit memory bus between the
//            CPU core bus master and the debugger memory-access port.
//            The core wins by default. A debugger access runs as a fixed
//            three-cycle sequence (setup, strobe, done) between core cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RESETN                 clock, asynchronous active-low reset
//   CORE_REQ/ADDR/DOUT/RDN/WRN* core bus master request and bus signals
//   CORE_GNT                    core owns the bus
//   DBG_REQ/WR/ADDR/WDATA       debugger access request (level, held to ACK)
//   DBG_ACK, DBG_RDATA          completion pulse and captured read data
//   DIN                         memory read data
//   ADDR/DOUT/RDN/WRN0/WRN1     shared bus pins (strobes active low)
//   ABUS_OEN                    address/data buffer enable, active low
// Configuration
//   MEM_BUS_ARB_STARVE_GUARD_EN defined   : a pending debugger request that
//       has been refused STARVE_LIMIT cycles wins the next IDLE arbitration.
//   MEM_BUS_ARB_STARVE_GUARD_EN undefined : strict core priority; the
//       debugger only starts in an IDLE cycle with CORE_REQ low, and
//       STARVE_LIMIT has no effect.
// ============================================================================
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        CORE_REQ,
    input  logic [15:0] CORE_ADDR,
    input  logic [15:0] CORE_DOUT,
    input  logic        CORE_RDN,
    input  logic        CORE_WRN0,
    input  logic        CORE_WRN1,
    output logic        CORE_GNT,
    input  logic        DBG_REQ,
    input  logic        DBG_WR,
    input  logic [15:0] DBG_ADDR,
    input  logic [15:0] DBG_WDATA,
    output logic        DBG_ACK,
    output logic [15:0] DBG_RDATA,
    input  logic [15:0] DIN,
    output logic [15:0] ADDR,
    output logic [15:0] DOUT,
    output logic        RDN,
    output logic        WRN0,
    output logic        WRN1,
    output logic        ABUS_OEN
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CORE    = 3'd1;
    localparam logic [2:0] c_DSETUP  = 3'd2;
    localparam logic [2:0] c_DSTROBE = 3'd3;
    localparam logic [2:0] c_DDONE   = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic        r_dbg_wr;
    logic [15:0] r_dbg_addr;
    logic [15:0] r_dbg_wdata;
    logic [15:0] r_dbg_rdata;
    logic        w_dbg_starved;
    logic        w_dbg_start;

`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_LIMIT = STARVE_LIMIT[3:0];

    logic [3:0] r_starve_cnt;
    logic       w_in_dbg;

    assign w_in_dbg = (r_state == c_DSETUP) || (r_state == c_DSTROBE) ||
                      (r_state == c_DDONE);

    // Counts cycles in which a debugger request waits outside its own
    // sequence; saturates so a long wait cannot wrap back to "not starved".
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_starve_cnt <= 4'd0;
        end else if (r_state == c_DDONE) begin
            r_starve_cnt <= 4'd0;
        end else if (DBG_REQ && !w_in_dbg && (r_starve_cnt != 4'hF)) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign w_dbg_starved = DBG_REQ && (r_starve_cnt >= c_STARVE_LIMIT);
`else
    assign w_dbg_starved = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_dbg_starved) begin
                    w_state_nxt = c_DSETUP;
                end else if (CORE_REQ) begin
                    w_state_nxt = c_CORE;
                end else if (DBG_REQ) begin
                    w_state_nxt = c_DSETUP;
                end
            end
            c_CORE: begin
                // A granted core cycle is never preempted.
                if (!CORE_REQ) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_DSETUP:  w_state_nxt = c_DSTROBE;
            c_DSTROBE: w_state_nxt = c_DDONE;
            c_DDONE:   w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    // Debugger request fields are captured on the edge that enters DSETUP so
    // that the bus already shows the latched address during DSETUP.
    assign w_dbg_start = (r_state == c_IDLE) && (w_state_nxt == c_DSETUP);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= c_IDLE;
            r_dbg_wr    <= 1'b0;
            r_dbg_addr  <= 16'd0;
            r_dbg_wdata <= 16'd0;
            r_dbg_rdata <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_dbg_start) begin
                r_dbg_wr    <= DBG_WR;
                r_dbg_addr  <= DBG_ADDR;
                r_dbg_wdata <= DBG_WDATA;
            end
            if ((r_state == c_DSTROBE) && !r_dbg_wr) begin
                r_dbg_rdata <= DIN;
            end
        end
    end

    // All outputs decode from state so an asynchronous reset takes effect on
    // the pins immediately.
    assign CORE_GNT  = (r_state == c_CORE);
    assign DBG_ACK   = (r_state == c_DDONE);
    assign DBG_RDATA = r_dbg_rdata;
    assign ABUS_OEN  = (r_state == c_IDLE);

    always_comb begin
        ADDR = r_dbg_addr;
        DOUT = r_dbg_wdata;
        RDN  = 1'b1;
        WRN0 = 1'b1;
        WRN1 = 1'b1;
        if (r_state == c_CORE) begin
            ADDR = CORE_ADDR;
            DOUT = CORE_DOUT;
            RDN  = CORE_RDN;
            WRN0 = CORE_WRN0;
            WRN1 = CORE_WRN1;
        end else if (r_state == c_DSTROBE) begin
            RDN  = r_dbg_wr;
            WRN0 = !r_dbg_wr;
            WRN1 = !r_dbg_wr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Purpose  : Self-checking bench for mem_bus_arbiter. Directed scenarios
//            followed by randomized core/debugger traffic, every cycle
//            compared against a transaction-level model of bus ownership.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int LIMIT = 4;
`ifdef MEM_BUS_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        CORE_REQ = 1'b0;
    logic [15:0] CORE_ADDR = 16'd0;
    logic [15:0] CORE_DOUT = 16'd0;
    logic        CORE_RDN = 1'b1;
    logic        CORE_WRN0 = 1'b1;
    logic        CORE_WRN1 = 1'b1;
    logic        CORE_GNT;
    logic        DBG_REQ = 1'b0;
    logic        DBG_WR = 1'b0;
    logic [15:0] DBG_ADDR = 16'd0;
    logic [15:0] DBG_WDATA = 16'd0;
    logic        DBG_ACK;
    logic [15:0] DBG_RDATA;
    logic [15:0] DIN = 16'd0;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        RDN;
    logic        WRN0;
    logic        WRN1;
    logic        ABUS_OEN;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) u_dut (
        .CLK(CLK), .RESETN(RESETN),
        .CORE_REQ(CORE_REQ), .CORE_ADDR(CORE_ADDR), .CORE_DOUT(CORE_DOUT),
        .CORE_RDN(CORE_RDN), .CORE_WRN0(CORE_WRN0), .CORE_WRN1(CORE_WRN1),
        .CORE_GNT(CORE_GNT),
        .DBG_REQ(DBG_REQ), .DBG_WR(DBG_WR), .DBG_ADDR(DBG_ADDR),
        .DBG_WDATA(DBG_WDATA), .DBG_ACK(DBG_ACK), .DBG_RDATA(DBG_RDATA),
        .DIN(DIN), .ADDR(ADDR), .DOUT(DOUT), .RDN(RDN), .WRN0(WRN0),
        .WRN1(WRN1), .ABUS_OEN(ABUS_OEN)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- reference model (bus ownership level) ----------------
    bit          m_core;      // core currently owns the bus
    int          m_dbg_left;  // debugger cycles remaining: 3 setup, 2 strobe, 1 done
    int          m_refused;   // cycles a debugger request has waited
    bit          m_wr;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    bit          last_ack;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_core     = 1'b0;
        m_dbg_left = 0;
        m_refused  = 0;
        m_wr       = 1'b0;
        m_addr     = 16'd0;
        m_wdata    = 16'd0;
        m_rdata    = 16'd0;
    endtask

    task automatic model_step();
        bit starved;
        int refused_next;
        if (!RESETN) begin
            model_reset();
            return;
        end
        starved      = GUARD && (m_refused >= LIMIT);
        refused_next = m_refused;
        if (DBG_REQ && (m_dbg_left == 0))
            refused_next = (m_refused < 15) ? m_refused + 1 : 15;
        if (m_core) begin
            m_core = CORE_REQ;
        end else if (m_dbg_left != 0) begin
            if ((m_dbg_left == 2) && !m_wr) m_rdata = DIN;
            if (m_dbg_left == 1) refused_next = 0;
            m_dbg_left--;
        end else if (DBG_REQ && (starved || !CORE_REQ)) begin
            m_dbg_left = 3;
            m_wr       = DBG_WR;
            m_addr     = DBG_ADDR;
            m_wdata    = DBG_WDATA;
        end else if (CORE_REQ) begin
            m_core = 1'b1;
        end
        m_refused = refused_next;
    endtask

    task automatic check_outputs();
        bit dbg_strobe;
        bit e_oen;
        dbg_strobe = (m_dbg_left == 2);
        e_oen      = !(m_core || (m_dbg_left != 0));
        check_eq("gnt",   16'(CORE_GNT), 16'(m_core));
        check_eq("ack",   16'(DBG_ACK),  16'(m_dbg_left == 1));
        check_eq("rdata", DBG_RDATA,     m_rdata);
        check_eq("oen",   16'(ABUS_OEN), 16'(e_oen));
        check_eq("rdn",   16'(RDN),  16'(m_core ? CORE_RDN  : !(dbg_strobe && !m_wr)));
        check_eq("wrn0",  16'(WRN0), 16'(m_core ? CORE_WRN0 : !(dbg_strobe && m_wr)));
        check_eq("wrn1",  16'(WRN1), 16'(m_core ? CORE_WRN1 : !(dbg_strobe && m_wr)));
        if (!e_oen)
            check_eq("addr", ADDR, m_core ? CORE_ADDR : m_addr);
        if (m_core || ((m_dbg_left != 0) && m_wr))
            check_eq("dout", DOUT, m_core ? CORE_DOUT : m_wdata);
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, then
    // return 1 time unit after the edge so the caller drives new inputs.
    task automatic tick();
        @(negedge CLK);
        check_outputs();
        last_ack = (m_dbg_left == 1);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_gnt"},   16'(CORE_GNT), 16'd0);
        check_eq({tag, "_ack"},   16'(DBG_ACK),  16'd0);
        check_eq({tag, "_rdata"}, DBG_RDATA,     16'd0);
        check_eq({tag, "_addr"},  ADDR,          16'd0);
        check_eq({tag, "_dout"},  DOUT,          16'd0);
        check_eq({tag, "_rdn"},   16'(RDN),      16'd1);
        check_eq({tag, "_wrn0"},  16'(WRN0),     16'd1);
        check_eq({tag, "_wrn1"},  16'(WRN1),     16'd1);
        check_eq({tag, "_oen"},   16'(ABUS_OEN), 16'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_at;
        int gnt_at;
        int cnt;
        model_reset();
        last_ack = 1'b0;

        // ---- reset state ----
        #1;
        check_reset_values("por");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESETN = 1'b1;

        // ---- core write access ----
        CORE_REQ = 1'b1; CORE_ADDR = 16'hfaaf; CORE_DOUT = 16'hffaf;
        CORE_RDN = 1'b1; CORE_WRN0 = 1'b0; CORE_WRN1 = 1'b0;
        tick();
        check_eq("core_gnt",  16'(CORE_GNT), 16'd1);
        check_eq("core_addr", ADDR,          16'hfaaf);
        check_eq("core_dout", DOUT,          16'hffaf);
        check_eq("core_wrn0", 16'(WRN0),     16'd0);
        check_eq("core_wrn1", 16'(WRN1),     16'd0);
        check_eq("core_oen",  16'(ABUS_OEN), 16'd0);
        CORE_REQ = 1'b0; CORE_WRN0 = 1'b1; CORE_WRN1 = 1'b1;
        tick();
        tick();

        // ---- debugger read ----
        DBG_REQ = 1'b1; DBG_WR = 1'b0; DBG_ADDR = 16'h4040; DIN = 16'h5555;
        ack_at = -1; cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            if (last_ack) DBG_REQ = 1'b0;
            tick();
            if (RDN === 1'b0) cnt++;
            if ((DBG_ACK === 1'b1) && (ack_at < 0)) begin
                ack_at = i;
                check_eq("dbg_rd_data", DBG_RDATA, 16'h5555);
            end
        end
        check_eq("dbg_rd_ack_cycle", 16'(ack_at), 16'd3);
        check_eq("dbg_rd_rdn_cycles", 16'(cnt), 16'd1);

        // ---- simultaneous requests: core first, debugger after release ----
        CORE_REQ = 1'b1; CORE_ADDR = 16'h0100; CORE_RDN = 1'b0;
        DBG_REQ = 1'b1; DBG_WR = 1'b1; DBG_ADDR = 16'h2222; DBG_WDATA = 16'h3333;
        ack_at = -1; gnt_at = -1;
        for (int i = 1; i <= 10; i++) begin
            if (last_ack) DBG_REQ = 1'b0;
            if (i == 4) begin CORE_REQ = 1'b0; CORE_RDN = 1'b1; end
            tick();
            if ((CORE_GNT === 1'b1) && (gnt_at < 0)) gnt_at = i;
            if ((DBG_ACK === 1'b1) && (ack_at < 0)) ack_at = i;
        end
        check_eq("simul_gnt_cycle", 16'(gnt_at), 16'd1);
        check_eq("simul_ack_cycle", 16'(ack_at), 16'd7);

        // ---- starvation: core re-requests as soon as it can ----
        CORE_REQ = 1'b1; CORE_ADDR = 16'h0400; CORE_RDN = 1'b0;
        DBG_REQ = 1'b1; DBG_WR = 1'b0; DBG_ADDR = 16'h0808;
        ack_at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if ((DBG_ACK === 1'b1) && (ack_at < 0)) ack_at = i;
            if (last_ack) DBG_REQ = 1'b0;
            if (CORE_REQ && m_core) CORE_REQ = 1'b0;
            else if (!CORE_REQ) CORE_REQ = 1'b1;
        end
        check_eq("starve_ack_cycle", 16'(ack_at), GUARD ? 16'd7 : 16'hffff);
        for (int i = 0; (i < 5) && CORE_REQ; i++) begin
            if (m_core) CORE_REQ = 1'b0;
            tick();
        end
        CORE_RDN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (last_ack) DBG_REQ = 1'b0;
            tick();
            if (DBG_ACK === 1'b1) cnt++;
        end
        check_eq("starve_late_ack", 16'(cnt), GUARD ? 16'd0 : 16'd1);

        // ---- reset during the strobe cycle of a debugger write ----
        DBG_REQ = 1'b1; DBG_WR = 1'b1; DBG_ADDR = 16'h1234; DBG_WDATA = 16'hbeef;
        tick();
        tick();
        check_eq("rst_pre_wrn0", 16'(WRN0), 16'd0);
        #2;
        RESETN = 1'b0;
        #1;
        model_reset();
        check_reset_values("arst");
        DBG_REQ = 1'b0;
        tick();
        RESETN = 1'b1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (DBG_ACK === 1'b1) cnt++;
        end
        check_eq("rst_no_ack", 16'(cnt), 16'd0);

        // ---- randomized traffic ----
        for (int c = 0; c < 3000; c++) begin
            if (!CORE_REQ) begin
                if ($urandom_range(0, 9) < 4) begin
                    CORE_REQ  = 1'b1;
                    CORE_ADDR = 16'($urandom);
                    CORE_DOUT = 16'($urandom);
                    {CORE_RDN, CORE_WRN0, CORE_WRN1} = 3'($urandom);
                end
            end else if (m_core && ($urandom_range(0, 1) == 1)) begin
                CORE_REQ = 1'b0;
            end
            if (DBG_REQ && last_ack) begin
                if ($urandom_range(0, 3) != 0) begin
                    DBG_REQ = 1'b0;
                end else begin
                    DBG_WR    = 1'($urandom);
                    DBG_ADDR  = 16'($urandom);
                    DBG_WDATA = 16'($urandom);
                end
            end else if (!DBG_REQ && ($urandom_range(0, 9) < 3)) begin
                DBG_REQ   = 1'b1;
                DBG_WR    = 1'($urandom);
                DBG_ADDR  = 16'($urandom);
                DBG_WDATA = 16'($urandom);
            end
            DIN = 16'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester arbiter and sequencer for the single external 16-bit memory bus of the ForthCPU. It sits between the `core` bus master (ADDR/DOUT/RDN/WRN0/WRN1), the debugger memory-access port and the board-level memory, and drives the shared bus pins.
- The core has priority by default.
- Debugger accesses are run as fixed three-cycle bus sequences inserted between core bus cycles.
- An optional starvation guard forces a debugger slot when the core is memory-bound.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of cycles a pending debugger request may be refused before it wins arbitration (1..15).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- CORE_REQ  in  1  core wants the bus; held high for the whole core bus cycle.
- CORE_ADDR  in  16  core address.
- CORE_DOUT  in  16  core write data.
- CORE_RDN  in  1  core read strobe, active low.
- CORE_WRN0  in  1  core low-byte write strobe, active low.
- CORE_WRN1  in  1  core high-byte write strobe, active low.
- CORE_GNT  out  1  core owns the bus; core stalls while CORE_REQ=1 and CORE_GNT=0.
- DBG_REQ  in  1  debugger access request; level, held until DBG_ACK.
- DBG_WR  in  1  1 = word write, 0 = word read; sampled with DBG_REQ.
- DBG_ADDR  in  16  debugger address.
- DBG_WDATA  in  16  debugger write data.
- DBG_ACK  out  1  one-cycle pulse when the debugger access completes.
- DBG_RDATA  out  16  read data captured for the debugger; held until the next debugger read.
- DIN  in  16  memory read data.
- ADDR  out  16  bus address.
- DOUT  out  16  bus write data.
- RDN  out  1  bus read strobe, active low.
- WRN0  out  1  bus low-byte write strobe, active low.
- WRN1  out  1  bus high-byte write strobe, active low.
- ABUS_OEN  out  1  address/data buffer enable, active low.

## Operation
States are IDLE, CORE, DSETUP, DSTROBE and DDONE.

- **IDLE**
  - Bus outputs: strobes high; ABUS_OEN=1.
  - Arbitration:
    - If DBG_REQ is pending and the debugger is starved, go to DSETUP.
    - Otherwise, if CORE_REQ=1, go to CORE.
    - Otherwise, if DBG_REQ=1, go to DSETUP.
  - Simultaneous requests go to the core unless the debugger is starved.
- **CORE**
  - CORE_GNT=1; ABUS_OEN=0.
  - ADDR, DOUT, RDN, WRN0 and WRN1 pass combinationally from the CORE_* inputs.
  - Leave to IDLE when CORE_REQ falls.
  - A core request is never preempted.
- **DSETUP**
  - Latch DBG_WR, DBG_ADDR and DBG_WDATA into internal registers.
  - Bus outputs: ADDR = latched address; DOUT = latched write data; all strobes high; ABUS_OEN=0.
- **DSTROBE**
  - Read access: RDN=0.
  - Write access: WRN0=0 and WRN1=0.
  - On a read, DIN is captured into DBG_RDATA at the end of this cycle.
- **DDONE**
  - Strobes high; ABUS_OEN=0; address still held.
  - DBG_ACK=1 for this cycle.
  - Next state is IDLE.
- **Starvation counter**
  - Saturating 4-bit counter.
  - Increments each cycle that DBG_REQ=1 and the state is not a D* state.
  - Cleared in DDONE.
  - "Starved" means counter ≥ STARVE_LIMIT.
- **Reset**
  - RESETN low at any time returns to IDLE immediately (asynchronously). An in-flight debugger access is aborted with no DBG_ACK.
  - Reset values: CORE_GNT=0, DBG_ACK=0, DBG_RDATA=0, ADDR=0, DOUT=0, RDN=1, WRN0=1, WRN1=1, ABUS_OEN=1, counter=0.

## Timing
- Core grant latency: CORE_REQ rising in IDLE produces CORE_GNT=1 one cycle later.
- Minimum back-to-back core cycles:
  - Each core bus cycle is followed by at least one IDLE cycle.
  - Releasing and re-requesting therefore costs 2 cycles.
- Debugger access: DBG_REQ seen in IDLE produces DBG_ACK 3 cycles later (DSETUP, DSTROBE, DDONE).
- Write strobes last exactly one cycle, with address and data stable one cycle either side.
- DBG_RDATA is valid in the DBG_ACK cycle.
- DBG_REQ must drop in the cycle after DBG_ACK. If it is still high in that cycle, a new access starts.

## Configuration
Macro: MEM_BUS_ARB_STARVE_GUARD_EN.
- Defined: the starvation counter and STARVE_LIMIT behaviour are compiled in as described.
- Undefined:
  - The counter is removed and strict core priority applies.
  - The debugger is granted only in an IDLE cycle with CORE_REQ=0.
  - The STARVE_LIMIT parameter is ignored.

## Test plan
- **Reset during debugger access:** RESETN low during DSTROBE of a debugger write.
  - Strobes return high immediately.
  - No DBG_ACK.
  - All outputs take their reset values.
- **Core access:** CORE_REQ=1 with CORE_ADDR=16'hfaaf, CORE_DOUT=16'hffaf, CORE_WRN0=CORE_WRN1=0.
  - CORE_GNT=1 after 1 cycle.
  - Bus shows 16'hfaaf / 16'hffaf with both write strobes low.
  - ABUS_OEN=0.
- **Debugger read:** DBG_REQ=1, DBG_WR=0, DBG_ADDR=16'h4040, DIN=16'h5555.
  - RDN low for exactly one cycle.
  - DBG_ACK 3 cycles after the request.
  - DBG_RDATA=16'h5555.
- **Simultaneous requests:** CORE_REQ and DBG_REQ rise together, counter 0.
  - Core is granted first.
  - The debugger sequence starts after CORE_REQ falls.
- **Starvation guard** (guard enabled, STARVE_LIMIT=4): core issues continuous request/release pairs while DBG_REQ is held.
  - The debugger wins the first IDLE cycle after 4 refused cycles.
  - CORE_GNT stays 0 until DDONE.
- **Guard compiled out:** same stimulus as the starvation-guard test with the macro undefined.
  - The debugger is never served until CORE_REQ stays low in an IDLE cycle.
